// File: rtl/display_scan_mux.sv
// Multiplexed scan driver for a common-anode digit display: shadow-buffered digits,
// per-slot blanking, active-low anodes/dp, and a once-per-frame update handshake.
module display_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    update_req,
    output logic                    update_ack,
    output logic [3:0]              digit_out,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start,
    output logic                    dbg_state_o
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_END  = CW'(REFRESH_DIV - 1);

    typedef enum logic {BLANK = 1'b0, ON = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;

    logic                    load;
    logic [3:0]              sel_dig;
    logic                    lit;
    logic [3:0]              digit_out_d;
    logic                    dp_n_d;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic                    frame_start_d;

    assign dbg_state_o = state_q;

    // Loads happen only at the edge closing the frame_start cycle, so a frame never tears.
    assign load = frame_start & update_req;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 1'b1;
        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        sh_en_d  = sh_en_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_END) state_d = ON;
            end
            ON: begin
                if (cnt_q == SLOT_END) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
        if (load) begin
            sh_dig_d = digits_in;
            sh_dp_d  = dp_in;
            sh_en_d  = digit_en;
        end
    end

    // Outputs are decoded from next-state values so they register in step with the state.
    always_comb begin
        sel_dig       = sh_dig_d[{idx_d, 2'b00} +: 4];
        lit           = sh_en_d[idx_d] && (sel_dig <= 4'd9);
        digit_out_d   = lit ? sel_dig : 4'd0;
        anode_d       = '1;
        dp_n_d        = 1'b1;
        if (state_d == ON && lit) begin
            anode_d[idx_d] = 1'b0;
            dp_n_d         = ~sh_dp_d[idx_d];
        end
        frame_start_d = (state_d == BLANK) && (idx_d == '0) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            sh_dig_q    <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            anode       <= '1;
            digit_out   <= 4'd0;
            dp_n        <= 1'b1;
            update_ack  <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sh_dig_q    <= sh_dig_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            anode       <= anode_d;
            digit_out   <= digit_out_d;
            dp_n        <= dp_n_d;
            update_ack  <= load;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Time-multiplexed scan driver for the common-anode multi-digit display of the real-time clock.
- Holds a shadow copy of the BCD digits, dots and enables supplied by the timekeeping logic and presents one digit at a time on digit_out. digit_out feeds the seven-segment decoder.
- Drives the active-low anode lines and the active-low decimal point.
- Inserts a blanking interval between digit slots to prevent ghosting.
- Never presents a non-BCD value to the decoder.

Parameters:
- NUM_DIGITS, 8: number of display digits/slots; legal range 2..8.
- REFRESH_DIV, 100000: clock cycles per digit slot (blank + on); must be greater than BLANK_CYCLES+1.
- BLANK_CYCLES, 1000: cycles per slot with all anodes off; must be at least 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- digits_in  input  4*NUM_DIGITS  BCD digits; slot i = digits_in[4i+3:4i]; slot 0 = rightmost digit
- dp_in  input  NUM_DIGITS  decimal point request per slot, 1 = lit
- digit_en  input  NUM_DIGITS  slot enable, 1 = displayed
- update_req  input  1  requester holds high until update_ack
- update_ack  output  1  one-cycle pulse: shadow registers were loaded
- digit_out  output  4  BCD value to the decoder
- dp_n  output  1  decimal point, active-low
- anode  output  NUM_DIGITS  anode drive, active-low; at most one bit low
- frame_start  output  1  high in the first cycle of slot 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state and outputs are registered on rising clk.
- Reset (also when applied mid-scan):
  - state=BLANK, idx=0, cnt=0
  - shadow digits=0, shadow dp=0, shadow enables=0
  - anode all 1, digit_out=0, dp_n=1, update_ack=0
- Cycle after reset release:
  - frame_start=1.
  - The scan restarts cleanly at slot 0; no partial slot is emitted.
- FSM states: BLANK, ON. cnt counts cycles within the slot, 0..REFRESH_DIV-1.
- BLANK:
  - anode all 1, dp_n=1.
  - digit_out = sanitized shadow digit[idx], presented early so the decoder settles before the anode turns on.
  - When cnt reaches BLANK_CYCLES-1, move to ON.
- ON:
  - anode[idx]=0 only if shadow enable[idx]=1 and shadow digit[idx]<=9.
  - dp_n = ~shadow dp[idx] under the same condition, otherwise 1.
  - When cnt reaches REFRESH_DIV-1: cnt=0, idx=idx+1, wrapping NUM_DIGITS-1 -> 0; move to BLANK.
- Sanitizing: a shadow digit >9 or a disabled slot gives digit_out=0 and the slot stays dark. Values 10..15 are never output.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. frame_start=1 exactly when state=BLANK, idx=0, cnt=0.
- Shadow load and handshake:
  - Load happens at the edge ending a frame_start cycle when update_req=1. All of digits_in, dp_in and digit_en are captured atomically.
  - update_ack=1 for the single following cycle.
  - At most one load per frame, so the display never tears mid-frame.
  - If update_req is still high after ack, the next load occurs at the next frame_start.
  - If update_req rises mid-frame, it waits up to one frame.
  - If update_req drops before frame_start, no load and no ack.
  - Inputs are ignored at all other times.
- Pre-load value: in the slot-0 BLANK cycle where frame_start=1, digit_out shows the pre-load value. This is harmless because anodes are off and BLANK_CYCLES is at least 2.
- Anode invariant: at most one anode bit low in every cycle, including across reset and wrap.

Test Plan:
- Setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=10, BLANK_CYCLES=2, giving a 40-cycle frame.
- Reset, then hold update_req=1, digits_in=16'h1234, digit_en=4'hF, dp_in=0:
  - update_ack pulses on cycle 1 after release.
  - On the following frames, anode sequence is 1110, 1101, 1011, 0111, each low for 8 cycles after 2 blank cycles.
  - digit_out per slot is 4, 3, 2, 1.
- Load digits_in=16'h0A59, digit_en=4'hF:
  - Slot 2 (value A) stays dark with digit_out=0 throughout.
  - Slot 0 displays 9; slot 1 displays 5.
- Load digit_en=4'b0011, dp_in=4'b0010:
  - anode bits 3 and 2 never go low.
  - dp_n=0 only during slot 1 ON cycles.
- Raise update_req at cycle 15 of a frame with new digits 16'h5678:
  - The display is unchanged until the next frame_start.
  - Ack arrives at the cycle after frame_start.
  - The next frame shows 8, 7, 6, 5.
- Assert reset for 1 cycle during slot 2 ON:
  - Next cycle anode=1111, digit_out=0, dp_n=1, shadow cleared.
  - frame_start=1 in the cycle after release.
  - The display stays dark until a new load.
- Whole run: assert that at most one anode bit is low in every cycle, and digit_out<=9 in every cycle.
